// File: rtl/hc_lane_dispatch.sv
// hc_lane_dispatch
//
// Spreads incoming lines across NUM_LANES kernel lanes in round-robin order.
// It then collects the kernel results back into the original order. Each lane
// has its own result FIFO. A result that arrives for the lane the collector is
// waiting on, while that lane's FIFO is empty, skips the FIFO and goes
// straight to data_out. That gives a one-cycle path from lane_valid_in to
// valid_out.
//
// Ports
//   clk, reset (async, active-low), flush (synchronous clear)
//   data_in / valid_in             : lines from the requestor
//   almost_full                    : requestor should stop issuing reads
//   lane_data_out / lane_valid_out : one-hot dispatch to kernel lanes
//   lane_data_in / lane_valid_in   : kernel results, any lanes per cycle
//   data_out / valid_out / ready_in: in-order result stream
//   in_flight                      : lines dispatched, not yet accepted
//   overflow                       : sticky drop indicator
module hc_lane_dispatch #(
    parameter int DATA_WIDTH   = 512,
    parameter int NUM_LANES    = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           flush,
    input  logic [DATA_WIDTH-1:0]                          data_in,
    input  logic                                           valid_in,
    output logic                                           almost_full,
    output logic [NUM_LANES*DATA_WIDTH-1:0]                lane_data_out,
    output logic [NUM_LANES-1:0]                           lane_valid_out,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]                lane_data_in,
    input  logic [NUM_LANES-1:0]                           lane_valid_in,
    output logic [DATA_WIDTH-1:0]                          data_out,
    output logic                                           valid_out,
    input  logic                                           ready_in,
    output logic [$clog2(NUM_LANES*FIFO_DEPTH+1)-1:0]      in_flight,
    output logic                                           overflow
);

    localparam int LW  = $clog2(NUM_LANES);
    localparam int FW  = $clog2(FIFO_DEPTH);
    localparam int CAP = NUM_LANES * FIFO_DEPTH;
    localparam int IW  = $clog2(CAP + 1);
    localparam logic [IW-1:0] CAP_V = IW'(CAP);
    localparam logic [IW-1:0] AF_V  = IW'(CAP - AFULL_MARGIN);

    logic [LW-1:0]                   dp_q, cp_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_q;
    logic [NUM_LANES-1:0]            lane_valid_q;
    logic [DATA_WIDTH-1:0]           data_out_q;
    logic                            valid_out_q;
    logic [IW-1:0]                   in_flight_q, in_flight_d;
    logic                            af_q, ovf_q;

    // Each pointer has one extra bit. It tells a full FIFO from an empty one
    // when the address bits are equal.
    logic [FW:0]           wr_ptr_q [NUM_LANES];
    logic [FW:0]           rd_ptr_q [NUM_LANES];
    logic [DATA_WIDTH-1:0] fifo_mem [NUM_LANES][FIFO_DEPTH];

    logic                 accept, drop_in, deq, can_pop, pop, bypass, drop_res;
    logic [NUM_LANES-1:0] empty, full, wr_en;

    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a signal unassigned and infer a latch.
    always_comb begin
        accept   = 1'b0;
        drop_in  = 1'b0;
        deq      = valid_out_q && ready_in;
        can_pop  = !valid_out_q || ready_in;
        empty    = '0;
        full     = '0;
        wr_en    = '0;
        pop      = 1'b0;
        bypass   = 1'b0;
        drop_res = 1'b0;

        if (valid_in && !flush) begin
            accept  = (in_flight_q != CAP_V);
            drop_in = (in_flight_q == CAP_V);
        end

        for (int i = 0; i < NUM_LANES; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][FW] != rd_ptr_q[i][FW]) &&
                       (wr_ptr_q[i][FW-1:0] == rd_ptr_q[i][FW-1:0]);
        end

        pop    = can_pop && !empty[cp_q];
        bypass = can_pop && empty[cp_q] && lane_valid_in[cp_q];

        for (int i = 0; i < NUM_LANES; i++) begin
            wr_en[i] = lane_valid_in[i] && !full[i] && !(bypass && (cp_q == LW'(i)));
        end
        drop_res = |(lane_valid_in & full);

        in_flight_d = in_flight_q + IW'(accept) - IW'(deq);
    end

    // NOTE: all state in clocked blocks uses non-blocking assignments. Every
    // register then updates from values sampled before the edge, whatever
    // order the statements run in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_q         <= '0;
            cp_q         <= '0;
            lane_data_q  <= '0;
            lane_valid_q <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            in_flight_q  <= '0;
            af_q         <= 1'b0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else if (flush) begin
            dp_q         <= '0;
            cp_q         <= '0;
            lane_valid_q <= '0;
            valid_out_q  <= 1'b0;
            in_flight_q  <= '0;
            af_q         <= 1'b0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            // Dispatch: the strobe lasts one cycle and the data slice holds.
            lane_valid_q <= '0;
            if (accept) begin
                lane_data_q[int'(dp_q)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                lane_valid_q[dp_q] <= 1'b1;
                dp_q               <= dp_q + 1'b1;   // power-of-two wrap
            end

            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            end

            // Collect strictly in lane order. This restores dispatch order.
            if (pop) begin
                data_out_q     <= fifo_mem[cp_q][rd_ptr_q[cp_q][FW-1:0]];
                valid_out_q    <= 1'b1;
                rd_ptr_q[cp_q] <= rd_ptr_q[cp_q] + 1'b1;
                cp_q           <= cp_q + 1'b1;
            end else if (bypass) begin
                data_out_q  <= lane_data_in[int'(cp_q)*DATA_WIDTH +: DATA_WIDTH];
                valid_out_q <= 1'b1;
                cp_q        <= cp_q + 1'b1;
            end else if (ready_in) begin
                valid_out_q <= 1'b0;
            end

            in_flight_q <= in_flight_d;
            af_q        <= (in_flight_d >= AF_V);
            if (drop_in || drop_res) ovf_q <= 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset. Clearing the pointers already
    // empties every FIFO, and a reset on a memory array would stop it from
    // mapping to RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en[i] && !flush)
                fifo_mem[i][wr_ptr_q[i][FW-1:0]] <= lane_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign lane_data_out  = lane_data_q;
    assign lane_valid_out = lane_valid_q;
    assign data_out       = data_out_q;
    assign valid_out      = valid_out_q;
    assign in_flight      = in_flight_q;
    assign almost_full    = af_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_hc_lane_dispatch.sv
// Testbench for hc_lane_dispatch.
// A behavioural model tracks the following:
//   - lines accepted (the dispatch lane is the accept count mod NUM_LANES);
//   - a queue of expected outputs;
//   - the in-flight count and the sticky overflow flag.
// The kernel lanes are emulated as per-lane fixed-latency echoes.
module tb_hc_lane_dispatch;

    localparam int DW  = 32;
    localparam int NL  = 4;
    localparam int FD  = 4;
    localparam int AFM = 2;
    localparam int CAP = NL * FD;
    localparam int IFW = $clog2(CAP + 1);

    logic                clk;
    logic                reset;
    logic                flush;
    logic [DW-1:0]       data_in;
    logic                valid_in;
    logic                almost_full;
    logic [NL*DW-1:0]    lane_data_out;
    logic [NL-1:0]       lane_valid_out;
    logic [NL*DW-1:0]    lane_data_in;
    logic [NL-1:0]       lane_valid_in;
    logic [DW-1:0]       data_out;
    logic                valid_out;
    logic                ready_in;
    logic [IFW-1:0]      in_flight;
    logic                overflow;

    hc_lane_dispatch #(
        .DATA_WIDTH  (DW),
        .NUM_LANES   (NL),
        .FIFO_DEPTH  (FD),
        .AFULL_MARGIN(AFM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .almost_full   (almost_full),
        .lane_data_out (lane_data_out),
        .lane_valid_out(lane_valid_out),
        .lane_data_in  (lane_data_in),
        .lane_valid_in (lane_valid_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .in_flight     (in_flight),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          lane;
        logic [DW-1:0] data;
    } res_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            lat [NL];
    res_t          pend [$];
    logic [DW-1:0] exp_q [$];
    int            if_model  = 0;
    int            peak      = 0;
    bit            ov_model  = 0;
    int            acc_cnt   = 0;
    logic [NL-1:0] exp_lvo   = '0;
    logic [DW-1:0] exp_ldata = '0;
    bit            stall_prev = 0;
    logic [DW-1:0] held      = '0;

    task automatic clear_model();
        if_model   = 0;
        ov_model   = 0;
        acc_cnt    = 0;
        exp_lvo    = '0;
        stall_prev = 0;
        exp_q.delete();
        pend.delete();
    endtask

    // One clock cycle. At the falling edge the task first compares the DUT
    // against the model's current state. It then advances the model using the
    // inputs that the coming rising edge will sample. After that edge, the
    // emulated kernels pick up new strobes and drive any results now due.
    task automatic tick();
        bit            acc;
        logic [DW-1:0] exp;
        @(negedge clk);
        if (!reset) begin
            clear_model();
        end else begin
            n_checks++;
            if (in_flight !== IFW'(if_model)) begin
                n_fail++;
                $display("FAIL in_flight cyc %0d: got %0d expected %0d", cyc, in_flight, if_model);
            end
            n_checks++;
            if (almost_full !== (if_model >= CAP - AFM)) begin
                n_fail++;
                $display("FAIL almost_full cyc %0d: got %0b expected %0b", cyc, almost_full, if_model >= CAP - AFM);
            end
            n_checks++;
            if (overflow !== ov_model) begin
                n_fail++;
                $display("FAIL overflow cyc %0d: got %0b expected %0b", cyc, overflow, ov_model);
            end
            n_checks++;
            if (lane_valid_out !== exp_lvo) begin
                n_fail++;
                $display("FAIL lane_valid_out cyc %0d: got %b expected %b", cyc, lane_valid_out, exp_lvo);
            end
            for (int i = 0; i < NL; i++) begin
                if (exp_lvo[i]) begin
                    n_checks++;
                    if (lane_data_out[i*DW +: DW] !== exp_ldata) begin
                        n_fail++;
                        $display("FAIL lane_data_out[%0d] cyc %0d: got %h expected %h", i, cyc, lane_data_out[i*DW +: DW], exp_ldata);
                    end
                end
            end
            if (stall_prev) begin
                n_checks++;
                if (valid_out !== 1'b1 || data_out !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc %0d: got v=%0b d=%h expected v=1 d=%h", cyc, valid_out, data_out, held);
                end
            end
            if (valid_out && ready_in) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output cyc %0d: got %h expected none", cyc, data_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (data_out !== exp) begin
                        n_fail++;
                        $display("FAIL data_out_order cyc %0d: got %h expected %h", cyc, data_out, exp);
                    end
                end
            end
            stall_prev = valid_out && !ready_in && !flush;
            held       = data_out;

            if (flush) begin
                clear_model();
            end else begin
                acc = valid_in && (if_model != CAP);
                if (valid_in && !acc) ov_model = 1;
                if_model = if_model + (acc ? 1 : 0) - ((valid_out && ready_in) ? 1 : 0);
                exp_lvo  = '0;
                if (acc) begin
                    exp_lvo[acc_cnt % NL] = 1'b1;
                    exp_ldata = data_in;
                    exp_q.push_back(data_in);
                    acc_cnt++;
                end
                if (if_model > peak) peak = if_model;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        lane_valid_in = '0;
        for (int i = 0; i < NL; i++) begin
            if (reset && lane_valid_out[i])
                pend.push_back('{cyc + lat[i] - 1, i, lane_data_out[i*DW +: DW]});
        end
        for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].due == cyc) begin
                lane_valid_in[pend[k].lane] = 1'b1;
                lane_data_in[pend[k].lane*DW +: DW] = pend[k].data;
                pend.delete(k);
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0 && if_model == 0 && pend.size() == 0 && !valid_out) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        data_in = '0; lane_data_in = '0; lane_valid_in = '0;
        set_lat(1, 1, 1, 1);
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (lane_valid_out !== '0 || valid_out !== 1'b0 || almost_full !== 1'b0 ||
            overflow !== 1'b0 || in_flight !== '0 || data_out !== '0 || lane_data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got lvo=%b v=%0b af=%0b ov=%0b if=%0d expected all zero",
                     lane_valid_out, valid_out, almost_full, overflow, in_flight);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Eight back-to-back lines with every kernel echoing 3 cycles after the
    // line was presented on data_in.
    task automatic test_back_to_back();
        bit ok;
        set_lat(3, 3, 3, 3);
        ready_in = 1'b1;
        peak = 0;
        for (int k = 0; k < 8; k++) begin
            valid_in = 1'b1;
            data_in  = $urandom;
            tick();
        end
        valid_in = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size());
        end
        n_checks++;
        if (peak != 4) begin
            n_fail++;
            $display("FAIL b2b_peak_in_flight: got %0d expected 4", peak);
        end
    endtask

    task automatic test_mixed_latency();
        bit            ok;
        logic [DW-1:0] b0;
        set_lat(5, 1, 3, 2);
        ready_in = 1'b1;
        b0 = $urandom;
        for (int k = 0; k < 4; k++) begin
            valid_in = 1'b1;
            data_in  = (k == 0) ? b0 : DW'($urandom);
            tick();
        end
        valid_in = 1'b0;
        for (int n = 0; n < 20 && !valid_out; n++) tick();
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== b0) begin
            n_fail++;
            $display("FAIL mixed_first_out: got v=%0b d=%h expected v=1 d=%h", valid_out, data_out, b0);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mixed_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        set_lat(2, 2, 2, 2);
        ready_in = 1'b0;
        for (int k = 0; k < 17; k++) begin
            valid_in = 1'b1;
            data_in  = $urandom;
            tick();
            if (k == 12) begin
                n_checks++;
                if (almost_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL afull_below: got %0b expected 0 at in_flight 13", almost_full);
                end
            end
            if (k == 13) begin
                n_checks++;
                if (almost_full !== 1'b1 || in_flight !== IFW'(14)) begin
                    n_fail++;
                    $display("FAIL afull_at_14: got af=%0b if=%0d expected af=1 if=14", almost_full, in_flight);
                end
            end
        end
        valid_in = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || in_flight !== IFW'(16) || lane_valid_out !== '0) begin
            n_fail++;
            $display("FAIL drop_17th: got ov=%0b if=%0d lvo=%b expected ov=1 if=16 lvo=0",
                     overflow, in_flight, lane_valid_out);
        end
        tick();
        ready_in = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drain: got ok=%0b ov=%0b expected ok=1 ov=1", ok, overflow);
        end
    endtask

    task automatic test_flush();
        bit ok;
        set_lat(3, 3, 3, 3);
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid_in = 1'b1;
            data_in  = $urandom;
            tick();
        end
        flush    = 1'b1;
        data_in  = $urandom;
        tick();
        flush    = 1'b0;
        valid_in = 1'b0;
        n_checks++;
        if (in_flight !== '0 || valid_out !== 1'b0 || overflow !== 1'b0 || lane_valid_out !== '0) begin
            n_fail++;
            $display("FAIL flush_clear: got if=%0d v=%0b ov=%0b lvo=%b expected all zero",
                     in_flight, valid_out, overflow, lane_valid_out);
        end
        ready_in = 1'b1;
        valid_in = 1'b1;
        data_in  = $urandom;
        tick();
        valid_in = 1'b0;
        n_checks++;
        if (lane_valid_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL flush_restart_lane: got %b expected 0001", lane_valid_out);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL flush_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // ready_in toggles every cycle while the requestor streams whenever
    // almost_full is low. The scoreboard catches loss, duplication and
    // changes of data_out during a stall.
    task automatic test_ready_toggle();
        bit ok;
        int sent;
        for (int i = 0; i < NL; i++) lat[i] = int'($urandom_range(1, 6));
        sent = 0;
        for (int n = 0; n < 400 && sent < 30; n++) begin
            ready_in = cyc[0];
            valid_in = !almost_full;
            data_in  = $urandom;
            if (!almost_full) sent++;
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok || sent != 30 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_drain: got ok=%0b sent=%0d ov=%0b expected ok=1 sent=30 ov=0", ok, sent, overflow);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        set_lat(2, 2, 2, 2);
        ready_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            valid_in = 1'b1;
            data_in  = $urandom;
            tick();
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (lane_valid_out !== '0 || valid_out !== 1'b0 || almost_full !== 1'b0 ||
            overflow !== 1'b0 || in_flight !== '0 || data_out !== '0 || lane_data_out !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got lvo=%b v=%0b if=%0d d=%h expected all zero",
                     lane_valid_out, valid_out, in_flight, data_out);
        end
        valid_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        valid_in = 1'b1;
        data_in  = $urandom;
        tick();
        n_checks++;
        if (lane_valid_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_restart_lane: got %b expected 0001", lane_valid_out);
        end
        for (int k = 0; k < 3; k++) begin
            data_in = $urandom;
            tick();
        end
        valid_in = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mixed_latency();
        test_overflow();
        test_flush();
        test_ready_toggle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
